// File: rtl/adc_capture_ctrl_pkg.sv
// Shared types and default widths for the ADC capture write-side sequencer.
package adc_ctrl_pkg;
    localparam int ADC_DATA_W = 16;
    localparam int ADC_CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        CAPTURE,
        DRAIN
    } cap_state_t;
endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Control, ADC sample and FIFO write-side signals of the capture sequencer.
interface adc_capture_ctrl_if
    import adc_ctrl_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W,
    parameter int CNT_W  = ADC_CNT_W
);
    logic              arm;
    logic              abort;
    logic              trig;
    logic [CNT_W-1:0]  capture_len;
    logic [CNT_W-1:0]  trig_delay;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              fifo_full;
    logic              fifo_wr_empty;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_din;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [CNT_W-1:0]  samples_written;

    modport master (
        output arm, abort, trig, capture_len, trig_delay, sample_valid, sample_data,
               fifo_full, fifo_wr_empty,
        input  fifo_wr_en, fifo_din, busy, done, overflow, samples_written
    );

    modport slave (
        input  arm, abort, trig, capture_len, trig_delay, sample_valid, sample_data,
               fifo_full, fifo_wr_empty,
        output fifo_wr_en, fifo_din, busy, done, overflow, samples_written
    );
endinterface

// File: rtl/adc_capture_ctrl_down_counter.sv
// Loadable down-counter with a zero flag; the enable is expected to be gated by the user.
module down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic [W-1:0] count,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (en)
            cnt <= cnt - W'(1);
    end

    assign count = cnt;
    assign zero  = (cnt == '0);
endmodule

// File: rtl/adc_capture_ctrl.sv
// Write-side sequencer: arm, trigger, programmable delay, gate capture_len sample slots
// into the width-converter FIFO, then wait for readout to drain before reporting done.
module adc_capture_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int DATA_W      = ADC_DATA_W,
    parameter int CNT_W       = ADC_CNT_W,
    parameter int DRAIN_GUARD = 8
) (
    input logic              wr_clk,
    input logic              wr_rst,
    adc_capture_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    cap_state_t       state, state_next;
    logic [CNT_W-1:0] len_q, dly_q, slot_cnt, written;
    logic             ovf_q, done_q;
    logic             accept_arm, slot_take, last_slot, drain_done;
    logic             dly_load, dly_en, dly_zero, guard_en, guard_zero;
    logic             wr_en, busy;
    logic [CNT_W-1:0] dly_count, guard_count;

    down_counter #(.W(CNT_W)) u_dly_cnt (
        .clk(wr_clk), .rst(wr_rst), .load(dly_load), .en(dly_en),
        .value(dly_q), .count(dly_count), .zero(dly_zero)
    );

    // Guard holds off trusting fifo_wr_empty until the reader-side flag has crossed over.
    down_counter #(.W(CNT_W)) u_guard_cnt (
        .clk(wr_clk), .rst(wr_rst), .load(last_slot), .en(guard_en),
        .value(CNT_W'(DRAIN_GUARD)), .count(guard_count), .zero(guard_zero)
    );

    always_ff @(posedge wr_clk) begin
        if (wr_rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.arm && bus.capture_len != '0) state_next = ARMED;
                ARMED:   if (bus.trig) state_next = (dly_q != '0) ? DELAY : CAPTURE;
                DELAY:   if (dly_count == ONE) state_next = CAPTURE;
                CAPTURE: if (last_slot) state_next = DRAIN;
                DRAIN:   if (drain_done) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        accept_arm = (state == IDLE) && bus.arm && !bus.abort;
        slot_take  = (state == CAPTURE) && bus.sample_valid;
        last_slot  = slot_take && (slot_cnt + ONE == len_q);
        wr_en      = slot_take && !bus.fifo_full;
        dly_load   = (state == ARMED) && bus.trig;
        dly_en     = (state == DELAY) && !dly_zero;
        guard_en   = (state == DRAIN) && !guard_zero;
        drain_done = (state == DRAIN) && (guard_count == '0) && bus.fifo_wr_empty && !bus.abort;
        busy       = (state != IDLE);
    end

    // Slots count even when the FIFO is full so the record stays aligned to the trigger.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            len_q    <= '0;
            dly_q    <= '0;
            slot_cnt <= '0;
            written  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept_arm) begin
                len_q    <= bus.capture_len;
                dly_q    <= bus.trig_delay;
                slot_cnt <= '0;
                written  <= '0;
                ovf_q    <= 1'b0;
                if (bus.capture_len == '0)
                    done_q <= 1'b1;
            end
            if (slot_take) begin
                slot_cnt <= slot_cnt + ONE;
                if (bus.fifo_full)
                    ovf_q <= 1'b1;
                else
                    written <= written + ONE;
            end
            if (drain_done)
                done_q <= 1'b1;
        end
    end

    assign bus.fifo_wr_en      = wr_en;
    assign bus.fifo_din        = bus.sample_data;
    assign bus.busy            = busy;
    assign bus.done            = done_q;
    assign bus.overflow        = ovf_q;
    assign bus.samples_written = written;
endmodule
